// File: rtl/and2_arbiter.sv
// Round-robin arbiter that time-shares one bit-sliced and2 bank between NREQ requesters.
// Each transaction walks IDLE -> GRANT -> EVAL -> DONE and returns a registered a & b result.

module and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module and2_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      y_out,
    output logic              y_valid,
    output logic [IDW-1:0]    y_id,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_next;
    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  pick;
    logic            pick_vld;
    logic [IDW:0]    cand;
    logic [NREQ-1:0] win_onehot;

    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    logic [W-1:0] op_a_p0;
    logic [W-1:0] op_b_p0;
    logic [W-1:0] and_y;
    logic [W-1:0] result_p1;

    // First requester at or after the pointer, wrapping from NREQ-1 back to 0.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!pick_vld && req[cand[IDW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_a = a_in[i*W +: W];
                sel_b = b_in[i*W +: W];
            end
        end
    end

    assign win_onehot = NREQ'(1) << winner;
    assign ptr_next   = (winner == IDW'(NREQ-1)) ? '0 : winner + IDW'(1);

    for (genvar g = 0; g < W; g++) begin : g_and2
        and2 u_and2 (
            .a (op_a_p0[g]),
            .b (op_b_p0[g]),
            .y (and_y[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            winner    <= '0;
            op_a_p0   <= '0;
            op_b_p0   <= '0;
            result_p1 <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick_vld) begin
                winner <= pick;
            end
            // Stage p0: operands frozen here, so later requester changes are ignored.
            if (state == GRANT) begin
                op_a_p0 <= sel_a;
                op_b_p0 <= sel_b;
            end
            // Stage p1: result register also serves as y_out and holds until the next DONE.
            if (state == EVAL) begin
                result_p1 <= and_y;
            end
            if (state == DONE) begin
                ptr <= ptr_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        gnt        = '0;
        ack        = '0;
        y_valid    = 1'b0;
        y_id       = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                gnt        = win_onehot;
                busy       = 1'b1;
                state_next = EVAL;
            end
            EVAL: begin
                gnt        = win_onehot;
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                gnt        = win_onehot;
                busy       = 1'b1;
                ack        = win_onehot;
                y_valid    = 1'b1;
                y_id       = winner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign y_out = result_p1;

endmodule

// File: tb/tb_and2_arbiter.sv
// Directed bench for and2_arbiter: reset, single grant, round-robin order,
// pointer wrap, mid-transaction reset, late req drop and back-to-back service.

module tb_and2_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   ack;
    logic [W-1:0]      y_out;
    logic              y_valid;
    logic [IDW-1:0]    y_id;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;

    and2_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .ack     (ack),
        .y_out   (y_out),
        .y_valid (y_valid),
        .y_id    (y_id),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int cycles, output bit seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < limit) begin
            step();
            cycles++;
            if (y_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic reset_dut();
        req   = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] obs;
        rst_n = 1'b1;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        #2 rst_n = 1'b0;
        #2;
        obs = {busy, gnt, ack, y_out, y_valid, y_id};
        vectors++;
        if (obs !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_async: outputs=%h required=0000", obs);
        end
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            obs = {busy, gnt, ack, y_out, y_valid, y_id};
            vectors++;
            if (obs !== 16'h0) begin
                miscompares++;
                $display("FAIL idle_no_req cycle %0d: outputs=%h required=0000", c, obs);
            end
        end
    endtask

    task automatic test_single();
        req  = 4'b0100;
        a_in = {4'h0, 4'b1011, 4'h0, 4'h0};
        b_in = {4'h0, 4'b0110, 4'h0, 4'h0};
        step();
        vectors++;
        if ({gnt, busy, ack} !== {4'b0100, 1'b1, 4'b0000}) begin
            miscompares++;
            $display("FAIL single_grant: gnt/busy/ack=%b required=%b", {gnt, busy, ack}, 9'b0100_1_0000);
        end
        req = '0;
        step();
        vectors++;
        if ({gnt, ack} !== {4'b0100, 4'b0000}) begin
            miscompares++;
            $display("FAIL single_eval: gnt/ack=%b required=01000000", {gnt, ack});
        end
        step();
        vectors++;
        if ({ack, y_valid, y_id, y_out, gnt} !== {4'b0100, 1'b1, 2'd2, 4'b0010, 4'b0100}) begin
            miscompares++;
            $display("FAIL single_done: ack=%b y_valid=%b y_id=%0d y_out=%b gnt=%b required 0100 1 2 0010 0100",
                     ack, y_valid, y_id, y_out, gnt);
        end
        step();
        vectors++;
        if ({ack, y_valid, gnt, busy, y_out} !== {4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0010}) begin
            miscompares++;
            $display("FAIL single_after: ack=%b y_valid=%b gnt=%b busy=%b y_out=%b required 0000 0 0000 0 0010",
                     ack, y_valid, gnt, busy, y_out);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        bit seen;
        int served[NREQ];
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [IDW-1:0] eid;
        for (int i = 0; i < NREQ; i++) served[i] = 0;
        reset_dut();
        a_in = {4'hF, 4'hF, 4'hF, 4'hF};
        b_in = {4'd4, 4'd3, 4'd2, 4'd1};
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_valid(8, cyc, seen);
            eid = IDW'(exp_id[k]);
            vectors++;
            if ({seen, y_id, y_out, ack} !== {1'b1, eid, W'(exp_id[k] + 1), NREQ'(1) << eid}) begin
                miscompares++;
                $display("FAIL rr_order #%0d: seen=%b y_id=%0d y_out=%0d ack=%b required id=%0d y_out=%0d",
                         k, seen, y_id, y_out, ack, exp_id[k], exp_id[k] + 1);
            end
            if (k > 0) begin
                vectors++;
                if (cyc !== 4) begin
                    miscompares++;
                    $display("FAIL rr_spacing #%0d: cycles=%0d required=4", k, cyc);
                end
            end
            if (k < 4 && seen) served[y_id]++;
        end
        for (int i = 0; i < NREQ; i++) begin
            vectors++;
            if (served[i] !== 1) begin
                miscompares++;
                $display("FAIL rr_fairness req%0d: acks=%0d required=1", i, served[i]);
            end
        end
    endtask

    task automatic test_pointer_wrap();
        int cyc;
        bit seen;
        req = 4'b1001;
        wait_valid(8, cyc, seen);
        vectors++;
        if ({seen, y_id, y_out, ack} !== {1'b1, 2'd3, 4'd4, 4'b1000}) begin
            miscompares++;
            $display("FAIL wrap_first: seen=%b y_id=%0d y_out=%0d ack=%b required id=3 y_out=4 ack=1000",
                     seen, y_id, y_out, ack);
        end
        wait_valid(8, cyc, seen);
        vectors++;
        if ({seen, y_id, y_out, ack} !== {1'b1, 2'd0, 4'd1, 4'b0001}) begin
            miscompares++;
            $display("FAIL wrap_second: seen=%b y_id=%0d y_out=%0d ack=%b required id=0 y_out=1 ack=0001",
                     seen, y_id, y_out, ack);
        end
        req = '0;
        step();
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit seen;
        logic [15:0] obs;
        req  = 4'b0100;
        a_in = {4'h0, 4'hF, 4'h0, 4'h0};
        b_in = {4'h0, 4'hF, 4'h0, 4'h0};
        step();
        step();
        rst_n = 1'b0;
        #1;
        obs = {busy, gnt, ack, y_out, y_valid, y_id};
        vectors++;
        if (obs !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid_async: outputs=%h required=0000", obs);
        end
        step();
        obs = {busy, gnt, ack, y_out, y_valid, y_id};
        vectors++;
        if (obs !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_mid_hold: outputs=%h required=0000", obs);
        end
        req   = 4'b0011;
        a_in  = {4'h0, 4'h0, 4'b1100, 4'b1001};
        b_in  = {4'h0, 4'h0, 4'b1010, 4'b0011};
        rst_n = 1'b1;
        wait_valid(8, cyc, seen);
        vectors++;
        if ({seen, y_id, y_out, ack} !== {1'b1, 2'd0, 4'b0001, 4'b0001}) begin
            miscompares++;
            $display("FAIL reset_mid_ptr0: seen=%b y_id=%0d y_out=%b ack=%b required id=0 y_out=0001 ack=0001",
                     seen, y_id, y_out, ack);
        end
        req = 4'b0010;
        wait_valid(8, cyc, seen);
        vectors++;
        if ({seen, y_id, y_out, ack} !== {1'b1, 2'd1, 4'b1000, 4'b0010}) begin
            miscompares++;
            $display("FAIL reset_mid_pending: seen=%b y_id=%0d y_out=%b ack=%b required id=1 y_out=1000 ack=0010",
                     seen, y_id, y_out, ack);
        end
        req = '0;
        step();
    endtask

    task automatic test_drop_req();
        req  = 4'b0010;
        a_in = {4'h0, 4'h0, 4'b0111, 4'h0};
        b_in = {4'h0, 4'h0, 4'b1101, 4'h0};
        step();
        vectors++;
        if (gnt !== 4'b0010) begin
            miscompares++;
            $display("FAIL drop_grant: gnt=%b required=0010", gnt);
        end
        step();
        req  = '0;
        a_in = '0;
        b_in = '0;
        step();
        vectors++;
        if ({ack, y_valid, y_id, y_out} !== {4'b0010, 1'b1, 2'd1, 4'b0101}) begin
            miscompares++;
            $display("FAIL drop_done: ack=%b y_valid=%b y_id=%0d y_out=%b required 0010 1 1 0101",
                     ack, y_valid, y_id, y_out);
        end
        step();
        vectors++;
        if ({busy, y_valid, y_out} !== {1'b0, 1'b0, 4'b0101}) begin
            miscompares++;
            $display("FAIL drop_hold: busy=%b y_valid=%b y_out=%b required 0 0 0101", busy, y_valid, y_out);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bit seen;
        req  = 4'b0001;
        a_in = {4'h0, 4'h0, 4'h0, 4'b1111};
        b_in = {4'h0, 4'h0, 4'h0, 4'b0110};
        wait_valid(8, cyc, seen);
        vectors++;
        if ({seen, y_id, y_out} !== {1'b1, 2'd0, 4'b0110}) begin
            miscompares++;
            $display("FAIL b2b_first: seen=%b y_id=%0d y_out=%b required 1 0 0110", seen, y_id, y_out);
        end
        wait_valid(8, cyc, seen);
        vectors++;
        if ({seen, y_id, cyc} !== {1'b1, 2'd0, 32'd4}) begin
            miscompares++;
            $display("FAIL b2b_second: seen=%b y_id=%0d cycles=%0d required 1 0 4", seen, y_id, cyc);
        end
        req = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_wrap();
        test_reset_mid();
        test_drop_req();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
